// File: rtl/mem_wait_ctrl.sv
// Wait-state controller for the memory bus: decodes on-chip / IO / off-chip
// regions, counts programmable wait states and exposes a 12-byte config window.
module mem_wait_ctrl #(
  parameter logic [31:0] CFG_BASE = 32'h1A10FFF4,
  parameter int unsigned CNT_W    = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_addr,
  input  logic [7:0]  mem_wdata,
  input  logic        ext_ready,
  output logic        mem_ready,
  output logic        bus_err,
  output logic [1:0]  region,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam logic [1:0] REG_ON  = 2'b00;
  localparam logic [1:0] REG_IO  = 2'b01;
  localparam logic [1:0] REG_OFF = 2'b10;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] limit;
  logic [1:0]       region_q;
  logic [7:0]       io_ws;
  logic [CNT_W-1:0] on_ws;
  logic [CNT_W-1:0] off_ws;

  logic             strobe;
  logic             is_io;
  logic             is_off;
  logic [1:0]       dec_region;
  logic [31:0]      cfg_off;
  logic             cfg_wr;

  assign strobe     = mem_read | mem_write;
  assign is_io      = (mem_addr[31:20] == 12'h1A1) && (mem_addr[19:17] == 3'b000);
  assign is_off     = (mem_addr[31:12] != 20'h0) && !is_io;
  assign dec_region = is_io ? REG_IO : (is_off ? REG_OFF : REG_ON);
  assign cfg_off    = mem_addr - CFG_BASE;
  assign cfg_wr     = mem_ready & mem_write;

  assign region = region_q;
  assign busy   = (state != IDLE);

  always_comb begin
    state_nx  = state;
    mem_ready = 1'b0;
    bus_err   = 1'b0;
    case (state)
      IDLE: if (strobe) state_nx = WAIT;
      WAIT: begin
        if (!strobe) begin
          state_nx = IDLE;
        end else if (region_q == REG_OFF) begin
          // ext_ready wins over the timeout when both land in the same cycle
          if (ext_ready) begin
            mem_ready = 1'b1;
            state_nx  = DONE;
          end else if (cnt == limit) begin
            mem_ready = 1'b1;
            bus_err   = 1'b1;
            state_nx  = DONE;
          end
        end else if (cnt == limit) begin
          mem_ready = 1'b1;
          state_nx  = DONE;
        end
      end
      DONE: if (!strobe) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      limit    <= '0;
      region_q <= REG_ON;
    end else begin
      state <= state_nx;
      if (state == IDLE) begin
        if (strobe) begin
          region_q <= dec_region;
          cnt      <= '0;
          case (dec_region)
            REG_IO:  limit <= CNT_W'(io_ws);
            REG_OFF: limit <= off_ws;
            default: limit <= on_ws;
          endcase
        end
      end else if (state == WAIT) begin
        if (cnt != '1) cnt <= cnt + 1'b1;
      end
    end
  end

  // Byte lanes beyond bit 31 are not addressable through the window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      io_ws  <= 8'h05;
      on_ws  <= CNT_W'(32'h200);
      off_ws <= CNT_W'(32'h3FFF);
    end else if (cfg_wr) begin
      if (cfg_off == 32'd0) io_ws <= mem_wdata;
      for (int unsigned i = 0; i < CNT_W; i++) begin
        if ((i < 32) && (cfg_off == 32'(4 + i / 8))) on_ws[i]  <= mem_wdata[3'(i % 8)];
        if ((i < 32) && (cfg_off == 32'(8 + i / 8))) off_ws[i] <= mem_wdata[3'(i % 8)];
      end
    end
  end

endmodule

// File: tb/tb_mem_wait_ctrl.sv
// Bench for mem_wait_ctrl: directed accesses push expected completions into a
// scoreboard that an independent monitor checks against each mem_ready pulse.
module tb_mem_wait_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        ext_ready;
  logic        mem_ready, bus_err;
  logic [1:0]  region;
  logic        busy;

  mem_wait_ctrl #(.CFG_BASE(32'h1A10FFF4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .ext_ready(ext_ready),
    .mem_ready(mem_ready), .bus_err(bus_err), .region(region), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         edge_no;
    logic       err;
    logic [1:0] rg;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every mem_ready pulse must match the oldest expected completion.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (mem_ready === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_ready", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("ready_edge", cyc + 1, e.edge_no);
          chk("ready_bus_err", {31'd0, bus_err}, {31'd0, e.err});
          chk("ready_region", {30'd0, region}, {30'd0, e.rg});
        end
      end else if (bus_err === 1'b1) begin
        chk("bus_err_without_ready", 32'd1, 32'd0);
      end
    end
  end

  task automatic access(input logic [31:0] a, input logic rd, input logic wr,
                        input logic [7:0] d, input int n, input logic err,
                        input logic [1:0] rg, input int ext_cyc, input int hold);
    exp_t e;
    bit   got;
    @(negedge clk);
    mem_addr = a; mem_read = rd; mem_write = wr; mem_wdata = d; ext_ready = 1'b0;
    e.edge_no = cyc + 1 + n; e.err = err; e.rg = rg;
    sb.push_back(e);
    got = 1'b0;
    for (int i = 1; i <= 700 && !got; i++) begin
      @(negedge clk);
      ext_ready = (i == ext_cyc);
      #1 got = mem_ready;
    end
    if (!got) chk("ready_timeout", 32'd0, 32'd1);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      ext_ready = 1'b0;
      #1 chk("done_hold_busy", {31'd0, busy}, 32'd1);
    end
    @(negedge clk);
    ext_ready = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    @(negedge clk);
    #1 chk("idle_after_access", {31'd0, busy}, 32'd0);
  endtask

  // Strobes held for k cycles of WAIT, then dropped before any completion.
  task automatic abort_access(input logic [31:0] a, input logic rd, input logic wr,
                              input logic [7:0] d, input int k);
    @(negedge clk);
    mem_addr = a; mem_read = rd; mem_write = wr; mem_wdata = d; ext_ready = 1'b0;
    repeat (k) @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b0;
    @(negedge clk);
    #1 chk("abort_idle", {31'd0, busy}, 32'd0);
  endtask

  localparam logic [31:0] IO_RD  = 32'h1A100010;
  localparam logic [31:0] ON_RD  = 32'h00000100;
  localparam logic [31:0] OFF_RD = 32'h00200000;

  initial begin
    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; mem_addr = '0;
    mem_wdata = '0; ext_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready", {31'd0, mem_ready}, 32'd0);
    chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
    chk("rst_region", {30'd0, region}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    access(IO_RD, 1, 0, 8'h00, 6, 0, 2'b01, 0, 0);
    access(32'h1A10FFF8, 0, 1, 8'h03, 6, 0, 2'b01, 0, 0);
    access(32'h1A10FFF9, 0, 1, 8'h00, 6, 0, 2'b01, 0, 0);
    access(32'h1A10FFFA, 0, 1, 8'h00, 6, 0, 2'b01, 0, 0);
    access(32'h1A10FFFB, 0, 1, 8'h00, 6, 0, 2'b01, 0, 0);
    access(ON_RD, 1, 0, 8'h00, 4, 0, 2'b00, 0, 5);

    access(32'h1A10FFFC, 0, 1, 8'h0A, 6, 0, 2'b01, 0, 0);
    access(32'h1A10FFFD, 0, 1, 8'h00, 6, 0, 2'b01, 0, 0);
    access(32'h1A10FFFE, 0, 1, 8'h00, 6, 0, 2'b01, 0, 0);
    access(32'h1A10FFFF, 0, 1, 8'h00, 6, 0, 2'b01, 0, 0);
    access(OFF_RD, 1, 0, 8'h00, 3, 0, 2'b10, 3, 0);
    chk("region_held_idle", {30'd0, region}, 32'd2);
    access(OFF_RD, 1, 0, 8'h00, 11, 1, 2'b10, 0, 0);
    access(OFF_RD, 1, 0, 8'h00, 11, 0, 2'b10, 11, 0);

    access(32'h1A10FFF8, 0, 1, 8'h00, 6, 0, 2'b01, 0, 0);
    access(ON_RD, 1, 0, 8'h00, 1, 0, 2'b00, 0, 0);

    access(32'h1A10FFF4, 0, 1, 8'h02, 6, 0, 2'b01, 0, 0);
    access(IO_RD, 1, 0, 8'h00, 3, 0, 2'b01, 0, 0);
    access(32'h1A10FFF4, 1, 0, 8'h09, 3, 0, 2'b01, 0, 0);
    access(IO_RD, 1, 0, 8'h00, 3, 0, 2'b01, 0, 0);
    access(32'h1A10FFF4, 1, 1, 8'h01, 3, 0, 2'b01, 0, 0);
    access(IO_RD, 1, 0, 8'h00, 2, 0, 2'b01, 0, 0);

    abort_access(OFF_RD, 1, 0, 8'h00, 4);
    abort_access(32'h1A10FFF4, 0, 1, 8'h07, 1);
    access(IO_RD, 1, 0, 8'h00, 2, 0, 2'b01, 0, 0);

    @(negedge clk);
    mem_addr = OFF_RD; mem_read = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_ready", {31'd0, mem_ready}, 32'd0);
    chk("midrst_region", {30'd0, region}, 32'd0);
    mem_read = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    access(IO_RD, 1, 0, 8'h00, 6, 0, 2'b01, 0, 0);
    access(ON_RD, 1, 0, 8'h00, 513, 0, 2'b00, 0, 0);
    access(OFF_RD, 1, 0, 8'h00, 2, 0, 2'b10, 2, 0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
